// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode-0 slave, LSB first, with rx valid/ready port and one-deep tx holding register
module spi_slave #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] DEFAULT_TX = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sck,
   input  logic             nss,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_overrun,
   output logic             tx_underrun,
   output logic             frame_err,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nx;
   logic [2:0] sck_q, nss_q;
   logic [1:0] mosi_q;
   logic [CW-1:0] bit_cnt;
   logic [WIDTH-1:0] rx_shift, rx_next, tx_shift, tx_hold;
   logic tx_full, reload_pend;
   logic sck_rise, sck_fall, start, stop, rise, fall, done, load, write;
   always_comb begin
      sck_rise = sck_q[1] & ~sck_q[2];
      sck_fall = ~sck_q[1] & sck_q[2];
      start = (state == IDLE) & ~nss_q[1] & nss_q[2];
      // nss rise wins over any sck edge seen in the same cycle
      stop = (state == SHIFT) & nss_q[1] & ~nss_q[2];
      rise = (state == SHIFT) & ~stop & sck_rise;
      fall = (state == SHIFT) & ~stop & sck_fall;
      done = rise & (bit_cnt == LAST);
      load = start | (fall & reload_pend);
      write = tx_valid & ~tx_full;
      rx_next = {mosi_q[1], rx_shift[WIDTH-1:1]};
      state_nx = start ? SHIFT : stop ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_q <= '0;
         nss_q <= '1;
         mosi_q <= '0;
         bit_cnt <= '0;
         rx_shift <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         rx_overrun <= 1'b0;
         tx_shift <= '0;
         tx_hold <= '0;
         tx_full <= 1'b0;
         tx_underrun <= 1'b0;
         reload_pend <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sck_q <= {sck_q[1:0], sck};
         nss_q <= {nss_q[1:0], nss};
         mosi_q <= {mosi_q[0], mosi};
         bit_cnt <= (start | stop | done) ? '0 : rise ? bit_cnt + 1'b1 : bit_cnt;
         rx_shift <= rise ? rx_next : rx_shift;
         rx_data <= done ? rx_next : rx_data;
         rx_valid <= done | (rx_valid & ~rx_ready);
         rx_overrun <= done & rx_valid & ~rx_ready;
         tx_shift <= load ? (tx_full ? tx_hold : DEFAULT_TX) : fall ? tx_shift >> 1 : tx_shift;
         tx_hold <= write ? tx_data : tx_hold;
         tx_full <= write | (tx_full & ~load);
         tx_underrun <= load & ~tx_full;
         reload_pend <= done ? 1'b1 : (fall | stop) ? 1'b0 : reload_pend;
         frame_err <= stop & (bit_cnt != '0);
      end
   end
   assign busy = state != IDLE;
   assign miso_oe = busy;
   assign miso = busy & tx_shift[0];
   assign tx_ready = ~tx_full;
endmodule
